// File: rtl/trim_seq_gen_pkg.sv
//------------------------------------------------------------------------------
// trim_seq_gen_pkg : shared types and constants for the trim sequence generator
// Optional build macro: TRIM_PARITY_EN (adds one even-parity bit per frame)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package trim_seq_gen_pkg;

   localparam int          DEF_CODE_W   = 12;
   localparam logic [11:0] DEF_RST_CODE = 12'h800;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_SHIFT = 3'd2,
      ST_LATCH = 3'd3,
      ST_DWELL = 3'd4,
      ST_NEXT  = 3'd5
   } state_t;

   // Serial bits per frame: the code itself plus the optional parity bit
   function automatic int frame_bits(input int code_w);
`ifdef TRIM_PARITY_EN
      return code_w + 1;
`else
      return code_w;
`endif
   endfunction

endpackage

`default_nettype wire

// File: rtl/trim_seq_gen_ser.sv
//------------------------------------------------------------------------------
// trim_seq_gen_ser : bit-period divider and MSB-first serializer with ENCLK/DOUT
// Optional build macro: TRIM_PARITY_EN (even-parity bit appended after the LSB)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module trim_seq_gen_ser
   import trim_seq_gen_pkg::*;
#(
   parameter int CODE_W  = DEF_CODE_W,
   parameter int CLK_DIV = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clr_i,
   input  logic              load_i,
   input  logic [CODE_W-1:0] code_i,
   output logic              enclk_o,
   output logic              dout_o,
   output logic              busy_o,
   output logic              frame_done_o
);

   localparam int FB    = frame_bits(CODE_W);
   localparam int DIV_W = $clog2(CLK_DIV);
   localparam int BIT_W = $clog2(FB);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FB - 1);

   logic              active_q;
   logic [DIV_W-1:0]  div_q;
   logic [BIT_W-1:0]  bit_q;
   logic [FB-1:0]     sreg_q;
   logic              enclk_q;
   logic              dout_q;
   logic [FB-1:0]     frame_d;
   logic [DIV_W-1:0]  div_nx_d;

`ifdef TRIM_PARITY_EN
   assign frame_d = {code_i, ^code_i};
`else
   assign frame_d = code_i;
`endif

   assign div_nx_d = div_q + DIV_W'(1);

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         active_q <= 1'b0;
         div_q    <= '0;
         bit_q    <= '0;
         sreg_q   <= '0;
         enclk_q  <= 1'b0;
         dout_q   <= 1'b0;
      end else if (load_i) begin
         active_q <= 1'b1;
         div_q    <= '0;
         bit_q    <= '0;
         sreg_q   <= frame_d;
         dout_q   <= frame_d[FB-1];
         enclk_q  <= 1'b0;
      end else if (active_q) begin
         if (div_q == DIV_LAST) begin
            div_q   <= '0;
            enclk_q <= 1'b0;
            if (bit_q == BIT_LAST) begin
               active_q <= 1'b0;
               dout_q   <= 1'b0;
            end else begin
               bit_q  <= bit_q + BIT_W'(1);
               sreg_q <= sreg_q << 1;
               dout_q <= sreg_q[FB-2];
            end
         end else begin
            // ENCLK rises half-way through the bit so the chain samples a settled DOUT
            div_q   <= div_nx_d;
            enclk_q <= (div_nx_d >= DIV_HALF);
         end
      end
   end

   assign enclk_o      = enclk_q;
   assign dout_o       = dout_q;
   assign busy_o       = active_q;
   assign frame_done_o = (bit_q == BIT_LAST) && (div_q == DIV_LAST);

endmodule

`default_nettype wire

// File: rtl/trim_seq_gen.sv
//------------------------------------------------------------------------------
// trim_seq_gen : trim-code sequencer (single frame or LO..HI sweep) for BGR trim chain
// Optional build macro: TRIM_PARITY_EN (one even-parity bit per frame)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module trim_seq_gen
   import trim_seq_gen_pkg::*;
#(
   parameter int                CODE_W   = DEF_CODE_W,
   parameter int                CLK_DIV  = 4,
   parameter int                DWELL    = 1000,
   parameter logic [CODE_W-1:0] RST_CODE = CODE_W'(DEF_RST_CODE)
) (
   input  logic              clk50_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic              mode_i,
   input  logic [CODE_W-1:0] code_in_i,
   input  logic [CODE_W-1:0] code_lo_i,
   input  logic [CODE_W-1:0] code_hi_i,
   input  logic [CODE_W-1:0] step_i,
   output logic              enclk_o,
   output logic              dout_o,
   output logic              latch_o,
   output logic [CODE_W-1:0] trimcode_o,
   output logic              busy_o,
   output logic              done_o
);

   localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

   state_t            state_q;
   logic              start_q;
   logic              mode_q;
   logic [CODE_W-1:0] code_q;
   logic [CODE_W-1:0] hi_q;
   logic [CODE_W-1:0] step_q;
   logic [DW_W-1:0]   dwell_q;
   logic              latch_q;
   logic              busy_q;
   logic              done_q;
   logic [CODE_W-1:0] trimcode_q;

   logic              start_edge_d;
   logic [CODE_W:0]   nxt_d;
   logic              sweep_end_d;
   logic              ser_load_d;
   logic [CODE_W-1:0] ser_code_d;
   logic              ser_clr_d;
   logic              ser_busy;
   logic              ser_last;

   assign start_edge_d = start_i & ~start_q;
   // Extra MSB catches carry-out so the sweep never wraps past full scale
   assign nxt_d        = {1'b0, code_q} + {1'b0, step_q};
   assign sweep_end_d  = nxt_d[CODE_W] || (nxt_d[CODE_W-1:0] > hi_q);
   assign ser_clr_d    = abort_i && (state_q != ST_IDLE);
   assign ser_load_d   = (state_q == ST_LOAD) || ((state_q == ST_NEXT) && !sweep_end_d);
   assign ser_code_d   = (state_q == ST_NEXT) ? nxt_d[CODE_W-1:0] : code_q;

   trim_seq_gen_ser #(
      .CODE_W  (CODE_W),
      .CLK_DIV (CLK_DIV)
   ) u_ser (
      .clk_i        (clk50_i),
      .rst_i        (rst_i),
      .clr_i        (ser_clr_d),
      .load_i       (ser_load_d),
      .code_i       (ser_code_d),
      .enclk_o      (enclk_o),
      .dout_o       (dout_o),
      .busy_o       (ser_busy),
      .frame_done_o (ser_last)
   );

   always_ff @(posedge clk50_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         start_q    <= 1'b0;
         mode_q     <= 1'b0;
         code_q     <= '0;
         hi_q       <= '0;
         step_q     <= '0;
         dwell_q    <= '0;
         latch_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         trimcode_q <= RST_CODE;
      end else begin
         start_q <= start_i;
         latch_q <= 1'b0;
         done_q  <= 1'b0;
         if (ser_clr_d) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (start_edge_d && !abort_i) begin
                     state_q <= ST_LOAD;
                     busy_q  <= 1'b1;
                     mode_q  <= mode_i;
                     code_q  <= mode_i ? code_lo_i : code_in_i;
                     hi_q    <= code_hi_i;
                     step_q  <= (step_i == '0) ? CODE_W'(1) : step_i;
                  end
               end
               ST_LOAD: state_q <= ST_SHIFT;
               ST_SHIFT: begin
                  if (ser_busy && ser_last) begin
                     state_q    <= ST_LATCH;
                     latch_q    <= 1'b1;
                     trimcode_q <= code_q;
                  end
               end
               ST_LATCH: begin
                  if (mode_q) begin
                     state_q <= ST_DWELL;
                     dwell_q <= DW_W'(DWELL - 1);
                  end else begin
                     state_q <= ST_IDLE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
               ST_DWELL: begin
                  if (dwell_q == '0) state_q <= ST_NEXT;
                  else               dwell_q <= dwell_q - DW_W'(1);
               end
               ST_NEXT: begin
                  if (sweep_end_d) begin
                     state_q <= ST_IDLE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ST_SHIFT;
                     code_q  <= nxt_d[CODE_W-1:0];
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign latch_o    = latch_q;
   assign trimcode_o = trimcode_q;
   assign busy_o     = busy_q;
   assign done_o     = done_q;

endmodule

`default_nettype wire

// File: tb/tb_trim_seq_gen.sv
//------------------------------------------------------------------------------
// tb_trim_seq_gen : randomized self-checking bench for trim_seq_gen
// Honors TRIM_PARITY_EN for frame length and expected serial bits
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_trim_seq_gen;

   localparam int CODE_W  = 12;
   localparam int CLK_DIV = 4;
   localparam int DWELL   = 16;
`ifdef TRIM_PARITY_EN
   localparam int FB = CODE_W + 1;
`else
   localparam int FB = CODE_W;
`endif
   localparam int SHIFT_T = FB * CLK_DIV;
   localparam int PERIOD  = SHIFT_T + DWELL + 2;

   logic        clk = 1'b0;
   logic        rst, start, abort, mode;
   logic [11:0] code_in, lo, hi, step;
   logic        enclk, dout, latch, busy, done;
   logic [11:0] trimcode;

   int          cyc = 0;
   int          n_chk = 0;
   int          n_err = 0;
   logic [11:0] exp_trim;

   trim_seq_gen #(
      .CODE_W   (CODE_W),
      .CLK_DIV  (CLK_DIV),
      .DWELL    (DWELL),
      .RST_CODE (12'h800)
   ) dut (
      .clk50_i    (clk),
      .rst_i      (rst),
      .start_i    (start),
      .abort_i    (abort),
      .mode_i     (mode),
      .code_in_i  (code_in),
      .code_lo_i  (lo),
      .code_hi_i  (hi),
      .step_i     (step),
      .enclk_o    (enclk),
      .dout_o     (dout),
      .latch_o    (latch),
      .trimcode_o (trimcode),
      .busy_o     (busy),
      .done_o     (done)
   );

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One run from a START edge; abort_at < 0 means no abort, hold keeps START high
   task automatic run(input bit m, input logic [11:0] ci, input logic [11:0] l,
                      input logic [11:0] h, input logic [11:0] s,
                      input int abort_at, input bit hold);
      int          codes[$];
      int          exp_bits[$];
      int          bits_q[$];
      int          lat_q[$];
      int          tc_q[$];
      int          done_q[$];
      int          c, st, end_rel, n_exp, nb;
      bit          prev_en;
      logic [11:0] cv;

      // reference: list of frame codes, then the MSB-first bit stream they produce
      if (!m) codes.push_back(int'(ci));
      else begin
         c  = int'(l);
         st = (s == 12'd0) ? 1 : int'(s);
         forever begin
            codes.push_back(c);
            if (c + st > int'(h)) break;
            c = c + st;
         end
      end
      foreach (codes[j]) begin
         cv = 12'(codes[j]);
         for (int i = CODE_W - 1; i >= 0; i--) exp_bits.push_back(int'(cv[i]));
         if (FB > CODE_W) exp_bits.push_back(int'(^cv));
      end

      if (abort_at >= 0)  end_rel = abort_at + 20;
      else if (!m)        end_rel = 2 + SHIFT_T + 1 + 8;
      else                end_rel = 2 + SHIFT_T + (codes.size() - 1) * PERIOD + DWELL + 2 + 8;

      @(negedge clk);
      @(posedge clk);
      #1;
      mode = m; code_in = ci; lo = l; hi = h; step = s; start = 1'b1;
      prev_en = 1'b0;

      for (int rel = 0; rel <= end_rel; rel++) begin
         @(negedge clk);
         if (enclk && !prev_en) bits_q.push_back(int'(dout));
         prev_en = enclk;
         if (latch) begin
            lat_q.push_back(rel);
            tc_q.push_back(int'(trimcode));
         end
         if (done) begin
            done_q.push_back(rel);
            check("busy_at_done", busy, 1'b0);
         end
         if (rel == 0) check("busy_t0", busy, 1'b0);
         if (rel == 1) check("busy_load", busy, 1'b1);
         if (rel == 2 && !hold) start = 1'b0;
         if (rel == 3) begin
            code_in = 12'($urandom); lo = 12'($urandom); hi = 12'($urandom);
            step = 12'($urandom); mode = ~m;
         end
         if (abort_at >= 0) begin
            abort = (rel == abort_at);
            if (rel == 6 || rel == 10) start = 1'b1;
            if (rel == 7 || rel == 11) start = 1'b0;
            if (rel == abort_at + 1) begin
               check("abort_busy", busy, 1'b0);
               check("abort_enclk", enclk, 1'b0);
               check("abort_dout", dout, 1'b0);
            end
         end
      end
      start = 1'b0;
      abort = 1'b0;

      if (abort_at >= 0) begin
         n_exp = 0;
         for (int k = 0; k < FB; k++)
            if (2 + k * CLK_DIV + CLK_DIV / 2 <= abort_at) n_exp++;
         check("abort_rises", bits_q.size(), n_exp);
         check("abort_latch_cnt", lat_q.size(), 0);
         check("abort_done_cnt", done_q.size(), 0);
         check("abort_trim", trimcode, exp_trim);
      end else begin
         n_exp = exp_bits.size();
         check("rise_cnt", bits_q.size(), n_exp);
         check("latch_cnt", lat_q.size(), codes.size());
         check("done_cnt", done_q.size(), 1);
         if (done_q.size() > 0)
            check("done_time", done_q[0], lat_q.size() > 0 ?
                  (m ? lat_q[lat_q.size()-1] + DWELL + 2 : lat_q[lat_q.size()-1] + 1) : -1);
         exp_trim = 12'(codes[codes.size()-1]);
         check("final_trim", trimcode, exp_trim);
      end
      nb = (bits_q.size() < n_exp) ? bits_q.size() : n_exp;
      for (int i = 0; i < nb; i++) check("serial_bit", bits_q[i], exp_bits[i]);
      for (int i = 0; i < lat_q.size() && i < codes.size(); i++) begin
         check("latch_time", lat_q[i], 2 + SHIFT_T + i * PERIOD);
         check("latch_code", tc_q[i], codes[i]);
      end
   endtask

   initial begin
      int ab;
      int hh;
      rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0;
      code_in = '0; lo = '0; hi = '0; step = '0;
      exp_trim = 12'h800;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_enclk", enclk, 1'b0);
      check("rst_dout", dout, 1'b0);
      check("rst_latch", latch, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_trim", trimcode, 12'h800);

      run(1'b0, 12'hA5C, 12'h000, 12'h000, 12'h000, -1, 1'b0);

      // reset asserted for three cycles in the middle of a shift
      @(posedge clk);
      #1 mode = 1'b0; code_in = 12'h3C3; start = 1'b1;
      repeat (3) @(negedge clk);
      start = 1'b0;
      repeat (17) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_enclk", enclk, 1'b0);
      check("midrst_dout", dout, 1'b0);
      check("midrst_busy", busy, 1'b0);
      check("midrst_trim", trimcode, 12'h800);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_trim = 12'h800;
      repeat (3) @(negedge clk);
      check("postrst_busy", busy, 1'b0);

      run(1'b1, 12'h000, 12'h010, 12'h018, 12'h004, -1, 1'b0);
      run(1'b1, 12'h000, 12'hFFC, 12'hFFF, 12'h008, -1, 1'b0);
      run(1'b1, 12'h000, 12'h100, 12'h0F0, 12'h003, -1, 1'b0);
      run(1'b1, 12'h000, 12'h020, 12'h024, 12'h000, -1, 1'b0);
      run(1'b0, 12'h3C3, 12'h000, 12'h000, 12'h000, 19, 1'b0);

      // ABORT coinciding with a START edge in IDLE wins
      @(posedge clk);
      #1 abort = 1'b1; start = 1'b1; mode = 1'b0; code_in = 12'h123;
      @(posedge clk);
      #1 abort = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_beats_start", busy, 1'b0);
      start = 1'b0;

      run(1'b0, 12'h5A5, 12'h000, 12'h000, 12'h000, -1, 1'b1);

      for (int r = 0; r < 8; r++) begin
         lo = 12'($urandom);
         hh = int'(lo) + int'($urandom_range(0, 24));
         if (hh > 4095) hh = 4095;
         ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(13, 45)) : -1;
         run(1'($urandom), 12'($urandom), lo, 12'(hh), 12'($urandom_range(0, 6)), ab, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
